// File: rtl/mlp_pkg.sv
// Shared types for the MLP weight-memory path: read-owner tags carried
// alongside SRAM reads so returned data can be routed back to its requester.
package mlp_pkg;

    localparam int unsigned W_AW = 11;
    localparam int unsigned W_DW = 8;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_H = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e own;
    } rd_tag_t;

endpackage

// File: rtl/mlp_tag_pipe.sv
// Fixed-depth shift register of read tags, aligned with the SRAM read latency.
module mlp_tag_pipe
    import mlp_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_push,
    output rd_tag_t tag_head
);

    rd_tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_push;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_head = stage[DEPTH-1];

endmodule

// File: rtl/mlp_wmem_arbiter.sv
// Single-port weight SRAM arbiter: compute has priority, a starvation counter
// forces pending host requests through, and read data is routed back by tag.
module mlp_wmem_arbiter
    import mlp_pkg::*;
#(
    parameter int unsigned AW       = W_AW,
    parameter int unsigned DW       = W_DW,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          c_ren_i,
    input  logic [AW-1:0] c_addr_i,
    output logic          c_gnt_o,
    input  logic          c_lock_i,
    output logic          c_rvalid_o,
    output logic [DW-1:0] c_rdata_o,
    input  logic          h_valid_i,
    output logic          h_ready_o,
    input  logic          h_we_i,
    input  logic [AW-1:0] h_addr_i,
    input  logic [DW-1:0] h_wdata_i,
    output logic          h_rvalid_o,
    output logic [DW-1:0] h_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    logic       host_win;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_next;
    logic       force_host;
    logic       force_host_next;
    rd_tag_t    tag_push;
    rd_tag_t    tag_head;

    // Grants are gated by reset so every output is quiet while rst_ni is low.
    always_comb begin
        host_win  = rst_ni & h_valid_i & ~c_lock_i & (~c_ren_i | force_host);
        c_gnt_o   = rst_ni & c_ren_i & ~host_win;
        h_ready_o = host_win;
    end

    always_comb begin
        mem_en_o    = c_gnt_o | h_ready_o;
        mem_we_o    = h_ready_o & h_we_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (h_ready_o) begin
            mem_addr_o = h_addr_i;
            if (h_we_i) begin
                mem_wdata_o = h_wdata_i;
            end
        end else if (c_gnt_o) begin
            mem_addr_o = c_addr_i;
        end
    end

    always_comb begin
        wait_cnt_next   = wait_cnt;
        force_host_next = force_host;
        if (c_lock_i || h_ready_o) begin
            wait_cnt_next   = '0;
            force_host_next = 1'b0;
        end else if (h_valid_i) begin
            if (wait_cnt != 4'hF) begin
                wait_cnt_next = wait_cnt + 4'd1;
            end
            if (wait_cnt == WAIT_LAST) begin
                force_host_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt   <= '0;
            force_host <= 1'b0;
        end else begin
            wait_cnt   <= wait_cnt_next;
            force_host <= force_host_next;
        end
    end

    // Writes push an invalid tag so the pipe stays aligned with issue order.
    always_comb begin
        tag_push.vld = mem_en_o & ~mem_we_o;
        tag_push.own = h_ready_o ? OWN_H : OWN_C;
    end

    mlp_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .tag_push (tag_push),
        .tag_head (tag_head)
    );

    always_comb begin
        c_rvalid_o = rst_ni & tag_head.vld & (tag_head.own == OWN_C);
        h_rvalid_o = rst_ni & tag_head.vld & (tag_head.own == OWN_H);
        c_rdata_o  = c_rvalid_o ? mem_rdata_i : '0;
        h_rdata_o  = h_rvalid_o ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_mlp_wmem_arbiter.sv
// Directed bench for mlp_wmem_arbiter with a 1-cycle-latency SRAM model.
module tb_mlp_wmem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        c_ren_i;
    logic [10:0] c_addr_i;
    logic        c_gnt_o;
    logic        c_lock_i;
    logic        c_rvalid_o;
    logic [7:0]  c_rdata_o;
    logic        h_valid_i;
    logic        h_ready_o;
    logic        h_we_i;
    logic [10:0] h_addr_i;
    logic [7:0]  h_wdata_i;
    logic        h_rvalid_o;
    logic [7:0]  h_rdata_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [10:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;

    int checks = 0;
    int errors = 0;
    int wcount = 0;

    logic [7:0] sram [2048];

    always #5 clk_i = ~clk_i;

    mlp_wmem_arbiter #(
        .AW       (11),
        .DW       (8),
        .RD_LAT   (1),
        .MAX_WAIT (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .c_ren_i     (c_ren_i),
        .c_addr_i    (c_addr_i),
        .c_gnt_o     (c_gnt_o),
        .c_lock_i    (c_lock_i),
        .c_rvalid_o  (c_rvalid_o),
        .c_rdata_o   (c_rdata_o),
        .h_valid_i   (h_valid_i),
        .h_ready_o   (h_ready_o),
        .h_we_i      (h_we_i),
        .h_addr_i    (h_addr_i),
        .h_wdata_i   (h_wdata_i),
        .h_rvalid_o  (h_rvalid_o),
        .h_rdata_o   (h_rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // SRAM model: pre-filled with addr^5A, one cycle read latency.
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            if (mem_we_o) sram[mem_addr_o] = mem_wdata_o;
            else mem_rdata_i <= sram[mem_addr_o];
        end
    end

    function automatic logic [7:0] exp_word(input int a);
        if (a < 16) return 8'(8'hA0 + a);
        return 8'(a) ^ 8'h5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) sram[a] = 8'(a) ^ 8'h5A;
        mem_rdata_i = 8'h00;

        // Reset with every request asserted
        rst_ni = 1'b0; c_ren_i = 1'b1; c_addr_i = 11'h7FF; c_lock_i = 1'b1;
        h_valid_i = 1'b1; h_we_i = 1'b1; h_addr_i = 11'h7FF; h_wdata_i = 8'hFF;
        #1;
        for (int i = 0; i < 10; i++) begin
            #2;
            check("rst_outputs", 64'({c_gnt_o, c_rvalid_o, c_rdata_o, h_ready_o, h_rvalid_o,
                                      h_rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}),
                  64'd0);
            next_cycle();
        end
        rst_ni = 1'b1; c_ren_i = 1'b0; c_lock_i = 1'b0; h_valid_i = 1'b0; h_we_i = 1'b0;
        #2;
        check("idle_mem_en", 64'(mem_en_o), 64'd0);
        check("idle_rvalid", 64'({c_rvalid_o, h_rvalid_o}), 64'd0);
        next_cycle();

        // Host load of addr 0..15
        for (int i = 0; i < 16; i++) begin
            h_valid_i = 1'b1; h_we_i = 1'b1; h_addr_i = 11'(i); h_wdata_i = 8'(8'hA0 + i);
            #2;
            check("load_ready", 64'(h_ready_o), 64'd1);
            check("load_we", 64'(mem_we_o), 64'd1);
            check("load_addr", 64'(mem_addr_o), 64'(i));
            check("load_wdata", 64'(mem_wdata_o), 64'(8'hA0 + i));
            if (h_ready_o && mem_we_o) wcount++;
            next_cycle();
        end
        check("load_count", 64'(wcount), 64'd16);
        h_we_i = 1'b0; h_addr_i = 11'd5;
        #2;
        check("rb_ready", 64'(h_ready_o), 64'd1);
        check("rb_we", 64'(mem_we_o), 64'd0);
        next_cycle();
        h_valid_i = 1'b0;
        #2;
        check("rb_rvalid", 64'(h_rvalid_o), 64'd1);
        check("rb_rdata", 64'(h_rdata_o), 64'hA5);
        check("rb_no_c", 64'(c_rvalid_o), 64'd0);
        next_cycle();

        // Locked compute burst with host pending throughout
        c_lock_i = 1'b1; c_ren_i = 1'b1; h_valid_i = 1'b1; h_we_i = 1'b0; h_addr_i = 11'd7;
        for (int i = 0; i < 20; i++) begin
            c_addr_i = 11'(i);
            #2;
            check("lock_h_ready", 64'(h_ready_o), 64'd0);
            check("lock_c_gnt", 64'(c_gnt_o), 64'd1);
            if (i > 0) begin
                check("lock_c_rvalid", 64'(c_rvalid_o), 64'd1);
                check("lock_c_rdata", 64'(c_rdata_o), 64'(exp_word(i - 1)));
            end
            next_cycle();
        end
        c_lock_i = 1'b0; c_ren_i = 1'b0;
        #2;
        check("unlock_h_ready", 64'(h_ready_o), 64'd1);
        check("lock_last_rvalid", 64'(c_rvalid_o), 64'd1);
        check("lock_last_rdata", 64'(c_rdata_o), 64'(exp_word(19)));
        next_cycle();
        h_valid_i = 1'b0;
        #2;
        check("unlock_h_rvalid", 64'(h_rvalid_o), 64'd1);
        check("unlock_h_rdata", 64'(h_rdata_o), 64'hA7);
        next_cycle();

        // Starvation: continuous compute, host read forced through on 5th cycle
        c_ren_i = 1'b1; c_addr_i = 11'd3; h_valid_i = 1'b1; h_we_i = 1'b0; h_addr_i = 11'd9;
        for (int w = 1; w <= 5; w++) begin
            #2;
            if (w < 5) begin
                check("starve_h_wait", 64'(h_ready_o), 64'd0);
                check("starve_c_gnt", 64'(c_gnt_o), 64'd1);
            end else begin
                check("starve_forced", 64'(h_ready_o), 64'd1);
                check("starve_c_block", 64'(c_gnt_o), 64'd0);
                check("starve_addr", 64'(mem_addr_o), 64'd9);
            end
            if (w > 1) begin
                check("starve_c_rvalid", 64'(c_rvalid_o), 64'd1);
                check("starve_c_rdata", 64'(c_rdata_o), 64'hA3);
            end
            next_cycle();
        end
        h_valid_i = 1'b0;
        #2;
        check("starve_h_rvalid", 64'(h_rvalid_o), 64'd1);
        check("starve_h_rdata", 64'(h_rdata_o), 64'hA9);
        check("starve_no_c", 64'(c_rvalid_o), 64'd0);
        check("starve_cnt_clr", 64'(dut.wait_cnt), 64'd0);
        check("starve_force_clr", 64'(dut.force_host), 64'd0);
        next_cycle();
        h_valid_i = 1'b1;
        #2;
        check("post_force_c_wins", 64'(h_ready_o), 64'd0);
        check("post_force_c_rvalid", 64'(c_rvalid_o), 64'd1);
        next_cycle();
        c_ren_i = 1'b0; h_valid_i = 1'b0;
        #2;
        check("post_force_c_rdata", 64'(c_rdata_o), 64'hA3);
        next_cycle();

        // Host write then compute read of the same address
        h_valid_i = 1'b1; h_we_i = 1'b1; h_addr_i = 11'd50; h_wdata_i = 8'h3C;
        #2;
        check("wr_ready", 64'(h_ready_o), 64'd1);
        next_cycle();
        h_valid_i = 1'b0; h_we_i = 1'b0; c_ren_i = 1'b1; c_addr_i = 11'd50;
        #2;
        check("raw_c_gnt", 64'(c_gnt_o), 64'd1);
        next_cycle();
        c_ren_i = 1'b0;
        #2;
        check("raw_rvalid", 64'(c_rvalid_o), 64'd1);
        check("raw_rdata", 64'(c_rdata_o), 64'h3C);
        next_cycle();

        // Interleave compute addr 100 and host addr 200
        for (int i = 0; i < 10; i++) begin
            c_ren_i = (i % 2 == 0); c_addr_i = 11'd100;
            h_valid_i = (i % 2 == 1); h_we_i = 1'b0; h_addr_i = 11'd200;
            #2;
            check("il_c_gnt", 64'(c_gnt_o), 64'(i % 2 == 0));
            check("il_h_ready", 64'(h_ready_o), 64'(i % 2 == 1));
            if (i > 0) begin
                if (i % 2 == 1) begin
                    check("il_c_ret", 64'({c_rvalid_o, h_rvalid_o, c_rdata_o}), 64'h2_3E);
                end else begin
                    check("il_h_ret", 64'({h_rvalid_o, c_rvalid_o, h_rdata_o}), 64'h2_92);
                end
            end
            next_cycle();
        end
        c_ren_i = 1'b0; h_valid_i = 1'b0;
        #2;
        check("il_last_h", 64'({h_rvalid_o, c_rvalid_o, h_rdata_o}), 64'h2_92);
        next_cycle();

        // Reset while a compute read is in flight
        c_ren_i = 1'b1; c_addr_i = 11'd2;
        #2;
        check("mid_c_gnt", 64'(c_gnt_o), 64'd1);
        next_cycle();
        rst_ni = 1'b0; c_ren_i = 1'b0;
        #2;
        check("mid_rst_rvalid0", 64'(c_rvalid_o), 64'd0);
        next_cycle();
        #2;
        check("mid_rst_rvalid1", 64'(c_rvalid_o), 64'd0);
        next_cycle();
        rst_ni = 1'b1;
        #2;
        check("mid_rel_rvalid", 64'({c_rvalid_o, h_rvalid_o}), 64'd0);
        next_cycle();
        c_ren_i = 1'b1; c_addr_i = 11'd4;
        #2;
        check("mid_new_gnt", 64'(c_gnt_o), 64'd1);
        next_cycle();
        c_ren_i = 1'b0;
        #2;
        check("mid_new_rvalid", 64'(c_rvalid_o), 64'd1);
        check("mid_new_rdata", 64'(c_rdata_o), 64'hA4);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mlp_wmem_arbiter.md
Name: mlp_wmem_arbiter

Overview:
- Shares the single-port weight SRAM (2048 x DW) between two requesters:
  - the MLP compute sequencer, which issues reads during layer evaluation;
  - the host loader, which writes weights at init and reads them back for debug.
- Sits between the MLP FSM's w_ren/w_addr outputs and the SRAM macro.
- Fixed priority goes to compute; a starvation counter guarantees host progress.
- Read data is returned to the requesting side with the SRAM read latency.

Parameters:
- AW, 11, SRAM address width (2048 words)
- DW, 8, SRAM data width
- RD_LAT, 1, SRAM read latency in cycles (1..3)
- MAX_WAIT, 4, cycles a pending host request may be refused while unlocked before it is forced through (1..15)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, synchronous, active-low
- c_ren_i  in  1  compute read request
- c_addr_i  in  AW  compute read address
- c_gnt_o  out  1  compute request issued to SRAM this cycle
- c_lock_i  in  1  compute burst lock; host is blocked while high
- c_rvalid_o  out  1  compute read data valid
- c_rdata_o  out  DW  compute read data
- h_valid_i  in  1  host request valid
- h_ready_o  out  1  host request accepted this cycle
- h_we_i  in  1  host write (1) / read (0)
- h_addr_i  in  AW  host address
- h_wdata_i  in  DW  host write data
- h_rvalid_o  out  1  host read data valid
- h_rdata_o  out  DW  host read data
- mem_en_o  out  1  SRAM enable
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  AW  SRAM address
- mem_wdata_o  out  DW  SRAM write data
- mem_rdata_i  in  DW  SRAM read data, valid RD_LAT cycles after a read enable

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset values: all registered state cleared, i.e. wait_cnt=0, force_host=0, tag pipe empty. Hence c_rvalid_o=0 and h_rvalid_o=0. All outputs are 0 while rst_ni=0.
- Grant logic is combinational from requests plus registered state.
  - host_win = h_valid_i & !c_lock_i & (!c_ren_i | force_host).
  - c_gnt_o = c_ren_i & !host_win.
  - h_ready_o = host_win.
- SRAM drive:
  - mem_en_o = c_gnt_o | h_ready_o.
  - mem_we_o = h_ready_o & h_we_i.
  - mem_addr_o / mem_wdata_o are muxed from the winner; mem_wdata_o is 0 when there is no host write.
- Host handshake: valid/ready. Once h_valid_i is asserted, the host holds h_we_i, h_addr_i and h_wdata_i stable until h_ready_o. A request is consumed on the cycle with h_valid_i & h_ready_o.
- Compute has no backpressure hold: an ungranted c_ren_i is the FSM's responsibility to repeat.
  - Under normal use c_lock_i is high during bursts, so compute is never refused.
- Starvation counter (wait_cnt, 4 bit):
  - increments when h_valid_i & !h_ready_o & !c_lock_i;
  - clears on h_ready_o, or when c_lock_i=1 (lock resets fairness).
  - force_host is registered: it is set when wait_cnt reaches MAX_WAIT-1 and is incremented that cycle, and cleared on h_ready_o.
- Lock: c_lock_i=1 forces h_ready_o=0 the same cycle, even if force_host=1. force_host is cleared by lock.
- Read return: a tag shift register of depth RD_LAT carries {valid, owner} per issued read.
  - Writes push an invalid tag.
  - At the output stage: c_rvalid_o = valid & owner==C; h_rvalid_o = valid & owner==H.
  - Both rdata outputs are driven from mem_rdata_i and are gated to 0 when the matching rvalid is 0.
  - Exactly one read is returned per issued read, in issue order. There is no reordering and no loss.
- Simultaneous requests, unlocked, force_host=0: compute wins.
- Same-cycle host write then compute read of the same address: the read is issued the next cycle and returns the new data, since SRAM write-before-read order is guaranteed by serialization.
- Reset mid-operation: the tag pipe is flushed. In-flight reads are dropped with no rvalid, and wait_cnt and force_host clear.

Decomposition:
- Package mlp_pkg holds:
  - localparams W_AW=11, W_DW=8;
  - typedef enum logic {OWN_C, OWN_H} owner_e;
  - typedef struct packed {logic vld; owner_e own;} rd_tag_t.
- One sub-module, mlp_tag_pipe: a parameterized RD_LAT-deep shift register of rd_tag_t with synchronous active-low clear.

Test Plan:
- Reset: hold rst_ni=0 for 10 cycles with all requests high -> every output 0; after release with idle inputs -> mem_en_o=0 and no rvalid.
- Host load: write addr 0..15 with data 8'hA0+i, no compute -> h_ready_o=1 every cycle; mem_we_o=1; 16 writes in 16 cycles; readback addr 5 -> h_rvalid_o one cycle later (RD_LAT=1) with 8'hA5.
- Lock: c_lock_i=1 for 20 cycles, compute reads addr 0..19, host valid throughout -> h_ready_o=0 for all 20 cycles; 20 c_rvalid_o pulses in order; host is accepted the first cycle after lock drops.
- Starvation: unlocked, c_ren_i=1 continuously, host read pending, MAX_WAIT=4 -> h_ready_o rises on the 5th cycle of waiting; c_gnt_o=0 that cycle; wait_cnt returns to 0.
- Interleave: alternate compute read addr 100 and host read addr 200 over 10 cycles -> each c_rvalid_o/h_rvalid_o pairs with the correct data; no cross-routing.
- Reset mid-read: issue a compute read, then assert rst_ni=0 the next cycle -> no c_rvalid_o; after reset the first new read returns correctly.
